// File: rtl/reg_write_arb_pkg.sv
// Shared types and the rotate-scan helper for the register write arbiter.
// Optional feature macro used by the top: REG_WRITE_ARB_LOCK_EN.
package reg_write_arb_pkg;

  // Widest requester vector the helper can scan; the arbiter supports 2..8.
  localparam int MAX_REQ   = 8;
  localparam int MAX_IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } pick_t;

  // First set bit of valid at or after ptr, wrapping at num.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                    input logic [MAX_IDX_W-1:0] ptr,
                                    input int unsigned          num);
    pick_t       r;
    int unsigned cand;
    r.found = 1'b0;
    r.idx   = {MAX_IDX_W{1'b0}};
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      cand = (32'(ptr) + k) % num;
      if ((k < num) && !r.found && valid[MAX_IDX_W'(cand)]) begin
        r.found = 1'b1;
        r.idx   = MAX_IDX_W'(cand);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating priority picker: finds the first valid requester
// starting at ptr and wrapping at NUM_REQ. Reusable by other arbiters.
module rr_priority_picker
  import reg_write_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  pick_t pick;

  // Widen to the helper's fixed width, scan, and narrow back.
  always_comb begin
    pick   = rr_pick(MAX_REQ'(valid), MAX_IDX_W'(ptr), NUM_REQ);
    found  = pick.found;
    winner = IDX_W'(pick.idx);
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register-bank write port between NUM_REQ
// requesters. The winning write is registered and held until wr_ready.
// Optional: define REG_WRITE_ARB_LOCK_EN to add req_lock, which lets the
// current owner keep the port for back-to-back atomic updates.
module reg_write_arbiter
  import reg_write_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int ADDR_WIDTH = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef REG_WRITE_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock,
`endif
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [IDX_W-1:0]              wr_src
);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] next_ptr;
  logic             slot_free;
  logic             relock;
  logic             grant;
`ifdef REG_WRITE_ARB_LOCK_EN
  logic             lock_held;
`endif

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid  (req_valid),
    .ptr    (rr_ptr),
    .found  (pick_found),
    .winner (pick_idx)
  );

  // Decide whether the port can take a new write and who gets it.
  always_comb begin
    slot_free = (state == IDLE) || ((state == HOLD) && wr_ready);
`ifdef REG_WRITE_ARB_LOCK_EN
    // Owner that locked its last grant keeps the port while still locking.
    relock = lock_held && (state == HOLD) && req_valid[wr_src] && req_lock[wr_src];
`else
    relock = 1'b0;
`endif
    if (relock) begin
      winner = wr_src;
    end else begin
      winner = pick_idx;
    end
    // Reset masks grants so nothing is accepted while the write is dropped.
    grant = slot_free && (relock || pick_found) && !reset;
    if (winner == IDX_W'(NUM_REQ - 1)) begin
      next_ptr = {IDX_W{1'b0}};
    end else begin
      next_ptr = winner + IDX_W'(1);
    end
  end

  // One-hot accept toward the winning requester only.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if (grant) begin
      req_ready[winner] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // FSM: capture on grant, drain to IDLE on accept with no new winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wr_valid  <= 1'b0;
      wr_addr   <= {ADDR_WIDTH{1'b0}};
      wr_data   <= {DATA_WIDTH{1'b0}};
      wr_src    <= {IDX_W{1'b0}};
      rr_ptr    <= {IDX_W{1'b0}};
`ifdef REG_WRITE_ARB_LOCK_EN
      lock_held <= 1'b0;
`endif
    end else if (grant) begin
      state    <= HOLD;
      wr_valid <= 1'b1;
      wr_addr  <= req_addr[32'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
      wr_data  <= req_data[32'(winner)*DATA_WIDTH +: DATA_WIDTH];
      wr_src   <= winner;
      // A locked re-grant leaves the rotation where it was.
      if (!relock) begin
        rr_ptr <= next_ptr;
      end
`ifdef REG_WRITE_ARB_LOCK_EN
      lock_held <= req_lock[winner];
`endif
    end else if (slot_free) begin
      state    <= IDLE;
      wr_valid <= 1'b0;
`ifdef REG_WRITE_ARB_LOCK_EN
      lock_held <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter with a spec-level reference model.
module tb_reg_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
`ifdef REG_WRITE_ARB_LOCK_EN
  logic [N-1:0]  req_lock = '0;
`endif
  logic          wr_valid;
  logic          wr_ready = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [IW-1:0] wr_src;

  int n_cmp = 0;
  int n_bad = 0;

  reg_write_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
`ifdef REG_WRITE_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_src    (wr_src)
  );

  always #5 clk = ~clk;

  // Reference model: one pending write slot plus a rotation pointer.
  bit            m_pending;
  int            m_ptr;
  int            m_src;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            m_lock;
  int            exp_win;
  bit            exp_locked;
  logic [N-1:0]  exp_ready;

  task automatic model_reset();
    m_pending = 0; m_ptr = 0; m_src = 0; m_addr = '0; m_data = '0; m_lock = 0;
  endtask

  task automatic model_eval();
    bit slot;
    slot = !m_pending || wr_ready;
    exp_win = -1;
    exp_locked = 0;
    exp_ready = '0;
    if (slot) begin
`ifdef REG_WRITE_ARB_LOCK_EN
      if (m_pending && m_lock && req_valid[m_src] && req_lock[m_src]) begin
        exp_win = m_src;
        exp_locked = 1;
      end
`endif
      for (int k = 0; k < N; k++)
        if (exp_win < 0 && req_valid[(m_ptr + k) % N]) exp_win = (m_ptr + k) % N;
    end
    if (exp_win >= 0) exp_ready[exp_win] = 1'b1;
  endtask

  task automatic model_clock();
    if (exp_win >= 0) begin
      m_pending = 1;
      m_src  = exp_win;
      m_addr = req_addr[exp_win*AW +: AW];
      m_data = req_data[exp_win*DW +: DW];
      if (!exp_locked) m_ptr = (exp_win + 1) % N;
`ifdef REG_WRITE_ARB_LOCK_EN
      m_lock = req_lock[exp_win];
`endif
    end else if (wr_ready) begin
      m_pending = 0;
    end
  endtask

  // Advance one clock with the model tracking it; returns at the negedge.
  task automatic tick();
    model_eval();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rand_payload();
    req_addr = N*AW'($urandom);
    req_data = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (wr_valid !== 1'b0 || req_ready !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_idle: wr_valid=%b req_ready=%b, need 0/0000", wr_valid, req_ready);
      end
    end
    n_cmp++;
    if (wr_addr !== 4'h0 || wr_data !== 8'h00 || wr_src !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_vals: addr=%h data=%h src=%0d, need 0", wr_addr, wr_data, wr_src);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL first_grant: req_ready=%b, need 0001", req_ready);
    end
    tick();
    n_cmp++;
    if (wr_valid !== 1'b1 || wr_src !== 2'd0) begin
      n_bad++;
      $display("FAIL first_write: wr_valid=%b src=%0d, need 1/0", wr_valid, wr_src);
    end
  endtask

  task automatic test_single();
    apply_reset();
    req_valid = 4'b0100;
    req_addr  = 16'h0300;
    req_data  = 32'h00A5_0000;
    wr_ready  = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL single_ready: req_ready=%b, need 0100", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    #1;
    n_cmp++;
    if (wr_valid !== 1'b1 || wr_addr !== 4'h3 || wr_data !== 8'hA5 || wr_src !== 2'd2) begin
      n_bad++;
      $display("FAIL single_write: v=%b a=%h d=%h s=%0d, need 1/3/a5/2",
               wr_valid, wr_addr, wr_data, wr_src);
    end
    tick();
    n_cmp++;
    if (wr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_drain: wr_valid=%b, need 0", wr_valid);
    end
  endtask

  task automatic test_rotation();
    apply_reset();
    req_valid = 4'b1111;
    wr_ready  = 1'b1;
    rand_payload();
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (wr_valid !== 1'b1 || wr_src !== IW'(k % N) || wr_addr !== m_addr) begin
        n_bad++;
        $display("FAIL rotation[%0d]: v=%b src=%0d addr=%h, need 1/%0d/%h",
                 k, wr_valid, wr_src, wr_addr, k % N, m_addr);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    req_valid = 4'b1111;
    wr_ready  = 1'b1;
    rand_payload();
    tick();
    wr_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if (req_ready !== 4'b0000 || wr_valid !== 1'b1 || wr_src !== 2'd0 ||
          wr_addr !== m_addr || wr_data !== m_data) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: rdy=%b v=%b s=%0d a=%h d=%h, need 0000/1/0/%h/%h",
                 c, req_ready, wr_valid, wr_src, wr_addr, wr_data, m_addr, m_data);
      end
      tick();
    end
    wr_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL bp_release: req_ready=%b, need 0010", req_ready);
    end
    tick();
    n_cmp++;
    if (wr_src !== 2'd1 || wr_data !== m_data) begin
      n_bad++;
      $display("FAIL bp_next: src=%0d data=%h, need 1/%h", wr_src, wr_data, m_data);
    end
  endtask

  task automatic test_reset_mid_hold();
    apply_reset();
    req_valid = 4'b0001;
    wr_ready  = 1'b0;
    tick();
    req_valid = 4'b1111;
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (wr_valid !== 1'b0 || req_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_async: wr_valid=%b req_ready=%b, need 0/0000", wr_valid, req_ready);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_ptr: req_ready=%b, need 0001", req_ready);
    end
    tick();
  endtask

`ifdef REG_WRITE_ARB_LOCK_EN
  task automatic test_lock();
    int exp_seq [5] = '{1, 1, 1, 2, 0};
    apply_reset();
    req_lock  = 4'b0000;
    wr_ready  = 1'b1;
    req_valid = 4'b0001;
    rand_payload();
    tick();
    req_valid = 4'b0111;
    req_lock  = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) begin
        req_valid = 4'b0101;
        req_lock  = 4'b0000;
      end
      tick();
      n_cmp++;
      if (wr_src !== IW'(exp_seq[k])) begin
        n_bad++;
        $display("FAIL lock_seq[%0d]: src=%0d, need %0d", k, wr_src, exp_seq[k]);
      end
    end
    req_lock = 4'b0000;
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      wr_ready  = ($urandom_range(0, 3) != 0);
`ifdef REG_WRITE_ARB_LOCK_EN
      req_lock  = N'($urandom);
`endif
      rand_payload();
      #1;
      model_eval();
      n_cmp++;
      if (req_ready !== exp_ready || wr_valid !== m_pending) begin
        n_bad++;
        $display("FAIL rand_ctl[%0d]: rdy=%b v=%b, need %b/%b",
                 c, req_ready, wr_valid, exp_ready, m_pending);
      end
      if (m_pending) begin
        n_cmp++;
        if (wr_addr !== m_addr || wr_data !== m_data || wr_src !== IW'(m_src)) begin
          n_bad++;
          $display("FAIL rand_data[%0d]: a=%h d=%h s=%0d, need %h/%h/%0d",
                   c, wr_addr, wr_data, wr_src, m_addr, m_data, m_src);
        end
      end
      tick();
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_reset_mid_hold();
`ifdef REG_WRITE_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
